// File: rtl/cmd_proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_proc_pkg
// Brief    : Shared types and constants for the command processor.
// Revision : 1.0 - initial release
// ============================================================================
package cmd_proc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        MOVE = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] CAL_OP    = 4'b0010;
    localparam logic [3:0] MOVE_OP   = 4'b0100;

    localparam logic [7:0] DFLT_ACK  = 8'hA5;
    localparam logic [7:0] DFLT_NACK = 8'h5A;

endpackage
`default_nettype wire

// File: rtl/cmd_proc_rise_det.sv
`default_nettype none
// ============================================================================
// Module   : rise_det
// Brief    : Rising-edge detector; compares the input against a registered
//            copy and flags the cycle in which it goes 0 -> 1.
// Revision : 1.0 - initial release
// ============================================================================
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic rise
);

    logic in_q;

    // One-cycle delayed copy of the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_q <= 1'b0;
        else        in_q <= in;
    end

    assign rise = in & ~in_q;

endmodule
`default_nettype wire

// File: rtl/cmd_proc.sv
`default_nettype none
// ============================================================================
// Module   : cmd_proc
// Brief    : Command processor: decodes calibrate / move commands, counts
//            centre-line IR crossings during a move and returns an ACK/NACK
//            byte to the UART wrapper.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_proc
    import cmd_proc_pkg::*;
#(
    parameter logic [7:0] ACK_CODE  = DFLT_ACK,
    parameter logic [7:0] NACK_CODE = DFLT_NACK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    input  logic        cal_done,
    input  logic        cntrIR,
    output logic        strt_cal,
    output logic        moving,
    output logic [11:0] dsrd_hdng,
    output logic        trmt,
    output logic [7:0]  resp
);

    state_t      state_q,    state_d;
    // Only the squares field is needed after the latch edge: the opcode is
    // decoded and the heading consumed in the same cycle the command is taken.
    logic [3:0]  sq_q,       sq_d;
    logic [4:0]  cnt_q,      cnt_d;
    logic [11:0] dsrd_q,     dsrd_d;
    logic        moving_q,   moving_d;
    logic        strt_cal_q, strt_cal_d;
    logic        trmt_q,     trmt_d;
    logic [7:0]  resp_q,     resp_d;
    logic        ir_rise;

    rise_det u_ir_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (cntrIR),
        .rise  (ir_rise)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sq_q       <= 4'h0;
            cnt_q      <= 5'd0;
            dsrd_q     <= 12'h000;
            moving_q   <= 1'b0;
            strt_cal_q <= 1'b0;
            trmt_q     <= 1'b0;
            resp_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            sq_q       <= sq_d;
            cnt_q      <= cnt_d;
            dsrd_q     <= dsrd_d;
            moving_q   <= moving_d;
            strt_cal_q <= strt_cal_d;
            trmt_q     <= trmt_d;
            resp_q     <= resp_d;
        end
    end

    // Next-state and next-output decode; pulses default low every cycle
    always_comb begin
        state_d     = state_q;
        sq_d        = sq_q;
        cnt_d       = cnt_q;
        dsrd_d      = dsrd_q;
        moving_d    = moving_q;
        strt_cal_d  = 1'b0;
        trmt_d      = 1'b0;
        resp_d      = resp_q;
        clr_cmd_rdy = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    sq_d        = cmd[3:0];
                    case (cmd[15:12])
                        CAL_OP: begin
                            strt_cal_d = 1'b1;
                            state_d    = CAL;
                        end
                        MOVE_OP: begin
                            // A zero heading means "north" exactly, not 0x00F
                            dsrd_d   = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
                            cnt_d    = 5'd0;
                            moving_d = 1'b1;
                            state_d  = MOVE;
                        end
                        default: begin
                            trmt_d  = 1'b1;
                            resp_d  = NACK_CODE;
                            state_d = RESP;
                        end
                    endcase
                end
            end

            CAL: begin
                if (cal_done) begin
                    trmt_d  = 1'b1;
                    resp_d  = ACK_CODE;
                    state_d = RESP;
                end
            end

            MOVE: begin
                // Two IR crossings per square; completion wins over a
                // coincident edge so the counter never overshoots the target.
                if (cnt_q == {sq_q, 1'b0}) begin
                    moving_d = 1'b0;
                    trmt_d   = 1'b1;
                    resp_d   = ACK_CODE;
                    state_d  = RESP;
                end else if (ir_rise) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign strt_cal  = strt_cal_q;
    assign moving    = moving_q;
    assign dsrd_hdng = dsrd_q;
    assign trmt      = trmt_q;
    assign resp      = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_proc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_proc
// Brief    : Directed bench for cmd_proc with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_proc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        cal_done;
    logic        cntrIR;
    logic        strt_cal;
    logic        moving;
    logic [11:0] dsrd_hdng;
    logic        trmt;
    logic [7:0]  resp;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic        trmt_prev = 1'b0;

    cmd_proc #(.ACK_CODE(8'hA5), .NACK_CODE(8'h5A)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cal_done    (cal_done),
        .cntrIR      (cntrIR),
        .strt_cal    (strt_cal),
        .moving      (moving),
        .dsrd_hdng   (dsrd_hdng),
        .trmt        (trmt),
        .resp        (resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle; it is taken on the following edge
    task automatic issue(input logic [15:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        #1;
        chk("clr_cmd_rdy_on_take", {31'd0, clr_cmd_rdy}, 32'd1);
        step();
        cmd_rdy = 1'b0;
        chk("clr_cmd_rdy_after_take", {31'd0, clr_cmd_rdy}, 32'd0);
    endtask

    // IR pulse that does not finish the move
    task automatic ir_pulse();
        cntrIR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 1) cntrIR = 1'b0;
            chk("moving_mid_move", {31'd0, moving}, 32'd1);
            chk("clr_cmd_rdy_in_move", {31'd0, clr_cmd_rdy}, 32'd0);
        end
    endtask

    // IR pulse whose edge reaches the target: move ends one cycle later
    task automatic ir_final();
        cntrIR = 1'b1;
        step();
        chk("moving_at_last_edge", {31'd0, moving}, 32'd1);
        step();
        cntrIR = 1'b0;
        chk("moving_after_done", {31'd0, moving}, 32'd0);
        chk("trmt_after_done", {31'd0, trmt}, 32'd1);
        chk("clr_cmd_rdy_in_resp", {31'd0, clr_cmd_rdy}, 32'd0);
        step();
        chk("trmt_one_cycle", {31'd0, trmt}, 32'd0);
    endtask

    // Scoreboard monitor: every transmit must match the next expected byte
    always @(negedge clk) begin
        if (rst_n && trmt) begin
            if (trmt_prev) chk("trmt_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_trmt", {24'd0, resp}, 32'hFFFF_FFFF);
            end else begin
                chk("resp", {24'd0, resp}, {24'd0, exp_q.pop_front()});
            end
        end
        trmt_prev <= rst_n && trmt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        cmd      = 16'h0000;
        cmd_rdy  = 1'b0;
        cal_done = 1'b0;
        cntrIR   = 1'b0;
        step();
        chk("rst_moving", {31'd0, moving}, 32'd0);
        chk("rst_dsrd",   {20'd0, dsrd_hdng}, 32'h000);
        chk("rst_resp",   {24'd0, resp}, 32'h00);
        chk("rst_trmt",   {31'd0, trmt}, 32'd0);
        rst_n = 1'b1;
        step();

        // Calibrate
        exp_q.push_back(8'hA5);
        issue(16'h2000);
        chk("strt_cal_high", {31'd0, strt_cal}, 32'd1);
        step();
        chk("strt_cal_one_cycle", {31'd0, strt_cal}, 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk("no_trmt_before_cal_done", {31'd0, trmt}, 32'd0);
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        chk("trmt_after_cal_done", {31'd0, trmt}, 32'd1);
        step();
        chk("trmt_cal_one_cycle", {31'd0, trmt}, 32'd0);

        // Move: heading 0x3F, 2 squares -> 4 IR rises
        exp_q.push_back(8'hA5);
        issue(16'h43F2);
        chk("dsrd_3ff", {20'd0, dsrd_hdng}, 32'h3FF);
        chk("moving_start", {31'd0, moving}, 32'd1);
        for (int i = 0; i < 3; i++) ir_pulse();
        ir_final();
        chk("dsrd_hold", {20'd0, dsrd_hdng}, 32'h3FF);

        // Stray cal_done outside CAL must do nothing
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        step();
        chk("cal_done_ignored", {31'd0, trmt}, 32'd0);

        // Unknown opcode
        exp_q.push_back(8'h5A);
        issue(16'hF123);
        chk("nack_trmt", {31'd0, trmt}, 32'd1);
        chk("nack_moving", {31'd0, moving}, 32'd0);
        chk("nack_strt_cal", {31'd0, strt_cal}, 32'd0);
        chk("nack_dsrd", {20'd0, dsrd_hdng}, 32'h3FF);
        step();

        // Zero heading, zero squares
        exp_q.push_back(8'hA5);
        issue(16'h4000);
        chk("zero_dsrd", {20'd0, dsrd_hdng}, 32'h000);
        chk("zero_moving", {31'd0, moving}, 32'd1);
        step();
        chk("zero_moving_drop", {31'd0, moving}, 32'd0);
        chk("zero_trmt", {31'd0, trmt}, 32'd1);
        step();

        // Command arriving mid-move waits for IDLE
        exp_q.push_back(8'hA5);
        issue(16'h4011);
        chk("q_dsrd", {20'd0, dsrd_hdng}, 32'h01F);
        cmd     = 16'h4A50;
        cmd_rdy = 1'b1;
        exp_q.push_back(8'hA5);
        ir_pulse();
        ir_final();
        chk("q_clr_in_idle", {31'd0, clr_cmd_rdy}, 32'd1);
        step();
        cmd_rdy = 1'b0;
        chk("q_dsrd_a5f", {20'd0, dsrd_hdng}, 32'hA5F);
        chk("q_moving", {31'd0, moving}, 32'd1);
        step();
        chk("q_trmt", {31'd0, trmt}, 32'd1);
        step();

        // Reset mid-move: 3 squares, abort after 2 of 6 pulses, no response
        issue(16'h4013);
        ir_pulse();
        ir_pulse();
        rst_n = 1'b0;
        #1;
        chk("arst_moving", {31'd0, moving}, 32'd0);
        chk("arst_dsrd",   {20'd0, dsrd_hdng}, 32'h000);
        chk("arst_resp",   {24'd0, resp}, 32'h00);
        chk("arst_trmt",   {31'd0, trmt}, 32'd0);
        chk("arst_strt",   {31'd0, strt_cal}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cntrIR = 1'b1;
            step();
            cntrIR = 1'b0;
            step();
        end
        chk("arst_idle_moving", {31'd0, moving}, 32'd0);

        exp_q.push_back(8'hA5);
        issue(16'h2000);
        chk("post_rst_strt_cal", {31'd0, strt_cal}, 32'd1);
        step();
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        chk("post_rst_trmt", {31'd0, trmt}, 32'd1);
        step();
        step();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
